cclut_lut_writer: RTL and testbench

CCLUT_LUT_WRITER -- requirements
Module: cclut_lut_writer

---
 rtl/cclut_lut_writer_if.sv | 38 +++
 rtl/cclut_lut_writer.sv | 154 +++++++++++++++
 tb/tb_cclut_lut_writer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cclut_lut_writer_if.sv
// cclut_lut_writer_if -- request and LUT-RAM bus of the CCLUT LUT writer.
//
// Host side : wr_req, wr_pid, wr_adr, wr_bend, wr_offs, clr_req  (to writer)
//             busy, wr_ack, wr_err, rb_err                       (from writer)
// RAM side  : lut_we, lut_re, lut_adr, lut_wdata                 (from writer)
//             lut_rdata                                          (to writer)
// Modports: slave = the writer, master = the host/RAM environment.
interface cclut_lut_writer_if #(
  parameter int MXADRB = 12,
  parameter int MXDATB = 9,
  parameter int NPID   = 5
);
  logic              wr_req;
  logic [3:0]        wr_pid;
  logic [MXADRB-1:0] wr_adr;
  logic [4:0]        wr_bend;
  logic [3:0]        wr_offs;
  logic              clr_req;
  logic              busy;
  logic              wr_ack;
  logic              wr_err;
  logic [NPID-1:0]   lut_we;
  logic [MXADRB-1:0] lut_adr;
  logic [MXDATB-1:0] lut_wdata;
  logic [NPID-1:0]   lut_re;
  logic [MXDATB-1:0] lut_rdata;
  logic              rb_err;

  modport slave (
    input  wr_req, wr_pid, wr_adr, wr_bend, wr_offs, clr_req, lut_rdata,
    output busy, wr_ack, wr_err, lut_we, lut_adr, lut_wdata, lut_re, rb_err
  );

  modport master (
    output wr_req, wr_pid, wr_adr, wr_bend, wr_offs, clr_req, lut_rdata,
    input  busy, wr_ack, wr_err, lut_we, lut_adr, lut_wdata, lut_re, rb_err
  );
endinterface

// File: rtl/cclut_lut_writer.sv
// cclut_lut_writer -- writes single entries into the per-pattern-ID CCLUT
// RAMs, or sweeps every address of every LUT with the default word
// (offset 7, bend 0).
//
// Ports:
//   clock  rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    cclut_lut_writer_if.slave: request handshake (wr_*/clr_req in,
//          busy/wr_ack/wr_err/rb_err out) and LUT RAM port (lut_we, lut_re,
//          lut_adr, lut_wdata out; lut_rdata in)
//
// Build option: define CCLUT_WR_READBACK_EN to read every single-entry write
// back and compare it (RDBK/CMP states, sticky rb_err). Without it lut_re and
// rb_err are tied low and lut_rdata is ignored.
module cclut_lut_writer #(
  parameter int MXADRB = 12,
  parameter int MXDATB = 9,
  parameter int NPID   = 5
) (
  input  logic             clock,
  input  logic             reset,
  cclut_lut_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
`ifdef CCLUT_WR_READBACK_EN
    RDBK  = 3'd2,
    CMP   = 3'd3,
`endif
    CLEAR = 3'd4,
    ACK   = 3'd5
  } state_t;

  localparam logic [MXDATB-1:0] CLR_WORD = MXDATB'(9'h0E0);
  localparam logic [3:0]        PID_LIM  = 4'(NPID);

  state_t            state_q, state_d;
  logic [3:0]        pid_q;
  logic [MXADRB-1:0] adr_q;
  logic [MXDATB-1:0] data_q;
  logic [MXADRB-1:0] cnt_q;
  logic              wr_err_q;
  logic              in_idle;
  logic              accept;
  logic              pid_ok;
  logic [NPID-1:0]   pid_onehot;

  assign in_idle    = (state_q == IDLE);
  assign accept     = in_idle && (bus.clr_req || bus.wr_req);
  assign pid_ok     = (bus.wr_pid < PID_LIM);
  assign pid_onehot = NPID'(1) << pid_q;

  // State register and control counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      // clr_req wins, so a simultaneous bad-pid write raises no error
      wr_err_q <= in_idle && !bus.clr_req && bus.wr_req && !pid_ok;
      // Runs only during the sweep; the final increment wraps it back to 0
      if (state_q == CLEAR)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  // Request capture (data path, not reset; every use is gated by state)
  always_ff @(posedge clock) begin
    if (in_idle && bus.wr_req && !bus.clr_req) begin
      pid_q  <= bus.wr_pid;
      adr_q  <= bus.wr_adr;
      data_q <= MXDATB'({bus.wr_offs, bus.wr_bend});
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req)
          state_d = CLEAR;
        else if (bus.wr_req && pid_ok)
          state_d = WRITE;
      end
`ifdef CCLUT_WR_READBACK_EN
      WRITE:   state_d = RDBK;
      RDBK:    state_d = CMP;
      CMP:     state_d = ACK;
`else
      WRITE:   state_d = ACK;
`endif
      CLEAR:   if (&cnt_q) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.lut_we    = '0;
    bus.lut_adr   = '0;
    bus.lut_wdata = '0;
    case (state_q)
      WRITE: begin
        bus.lut_we    = pid_onehot;
        bus.lut_adr   = adr_q;
        bus.lut_wdata = data_q;
      end
`ifdef CCLUT_WR_READBACK_EN
      RDBK, CMP: bus.lut_adr = adr_q;
`endif
      CLEAR: begin
        bus.lut_we    = '1;
        bus.lut_adr   = cnt_q;
        bus.lut_wdata = CLR_WORD;
      end
      default: ;
    endcase
  end

  assign bus.busy   = !in_idle;
  assign bus.wr_ack = (state_q == ACK);
  assign bus.wr_err = wr_err_q;

`ifdef CCLUT_WR_READBACK_EN
  logic rb_err_q;

  // Sticky mismatch flag; sets on the edge that enters ACK, so it rises
  // together with wr_ack, and clears when the next request is taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      rb_err_q <= 1'b0;
    else if (accept)
      rb_err_q <= 1'b0;
    else if (state_q == CMP && bus.lut_rdata != data_q)
      rb_err_q <= 1'b1;
  end

  assign bus.lut_re = (state_q == RDBK) ? pid_onehot : '0;
  assign bus.rb_err = rb_err_q;
`else
  logic unused_rdata;
  logic unused_accept;

  assign unused_rdata  = ^bus.lut_rdata;
  assign unused_accept = accept;
  assign bus.lut_re    = '0;
  assign bus.rb_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cclut_lut_writer.sv
module tb_cclut_lut_writer;

`ifdef CCLUT_WR_READBACK_EN
  localparam int ACK_CYC = 4;
`else
  localparam int ACK_CYC = 2;
`endif

  logic clk;
  logic rst;
  logic corrupt;
  int   n_chk;
  int   n_fail;
  logic [8:0] mem [5][4096];

  cclut_lut_writer_if #(.MXADRB(12), .MXDATB(9), .NPID(5)) bus ();

  cclut_lut_writer #(.MXADRB(12), .MXDATB(9), .NPID(5)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LUT RAM model: synchronous write, registered read, optional bit-0 fault
  always @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (bus.lut_we[p]) mem[p][bus.lut_adr] <= bus.lut_wdata;
      if (bus.lut_re[p]) bus.lut_rdata <= mem[p][bus.lut_adr] ^ {8'h00, corrupt};
    end
  end

  task automatic issue_write(input logic [3:0] pid, input logic [11:0] adr,
                             input logic [4:0] bend, input logic [3:0] offs);
    @(negedge clk);
    bus.wr_pid  = pid;
    bus.wr_adr  = adr;
    bus.wr_bend = bend;
    bus.wr_offs = offs;
    bus.wr_req  = 1'b1;
    @(posedge clk);
    #1 bus.wr_req = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    n_chk++; if (bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got=%b want=0", bus.wr_ack); end
    n_chk++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b want=0", bus.wr_err); end
    n_chk++; if (bus.lut_we !== 5'h00) begin n_fail++; $display("FAIL rst_we got=%h want=00", bus.lut_we); end
    n_chk++; if (bus.lut_re !== 5'h00) begin n_fail++; $display("FAIL rst_re got=%h want=00", bus.lut_re); end
    n_chk++; if (bus.lut_adr !== 12'h000) begin n_fail++; $display("FAIL rst_adr got=%h want=000", bus.lut_adr); end
    n_chk++; if (bus.lut_wdata !== 9'h000) begin n_fail++; $display("FAIL rst_wdata got=%h want=000", bus.lut_wdata); end
    n_chk++; if (bus.rb_err !== 1'b0) begin n_fail++; $display("FAIL rst_rberr got=%b want=0", bus.rb_err); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_write;
    logic [3:0]  v_pid  [3] = '{4'd3, 4'd0, 4'd4};
    logic [11:0] v_adr  [3] = '{12'h5A5, 12'h000, 12'hFFF};
    logic [4:0]  v_bend [3] = '{5'h13, 5'h1F, 5'h00};
    logic [3:0]  v_offs [3] = '{4'hB, 4'h0, 4'hF};
    logic [4:0]  v_we   [3] = '{5'b01000, 5'b00001, 5'b10000};
    logic [8:0]  v_wd   [3] = '{9'h173, 9'h01F, 9'h1E0};
    int ack_at, ack_cnt;
    for (int v = 0; v < 3; v++) begin
      issue_write(v_pid[v], v_adr[v], v_bend[v], v_offs[v]);
      @(negedge clk);  // cycle N+1
      n_chk++; if (bus.lut_we !== v_we[v]) begin n_fail++; $display("FAIL wr%0d_we got=%b want=%b", v, bus.lut_we, v_we[v]); end
      n_chk++; if (bus.lut_adr !== v_adr[v]) begin n_fail++; $display("FAIL wr%0d_adr got=%h want=%h", v, bus.lut_adr, v_adr[v]); end
      n_chk++; if (bus.lut_wdata !== v_wd[v]) begin n_fail++; $display("FAIL wr%0d_wdata got=%h want=%h", v, bus.lut_wdata, v_wd[v]); end
      n_chk++; if (bus.busy !== 1'b1 || bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr%0d_n1 busy=%b ack=%b want busy=1 ack=0", v, bus.busy, bus.wr_ack); end
      ack_at = 0;
      ack_cnt = 0;
      for (int k = 2; k <= ACK_CYC; k++) begin
        @(negedge clk);
`ifdef CCLUT_WR_READBACK_EN
        if (k == 2) begin
          n_chk++; if (bus.lut_re !== v_we[v] || bus.lut_we !== 5'h00) begin n_fail++; $display("FAIL wr%0d_rdbk re=%b we=%b want re=%b we=0", v, bus.lut_re, bus.lut_we, v_we[v]); end
        end
`endif
        if (bus.wr_ack === 1'b1) begin ack_cnt++; if (ack_at == 0) ack_at = k; end
      end
      n_chk++; if (ack_at !== ACK_CYC) begin n_fail++; $display("FAIL wr%0d_ack_cycle got=N+%0d want=N+%0d", v, ack_at, ACK_CYC); end
      @(negedge clk);
      if (bus.wr_ack === 1'b1) ack_cnt++;
      n_chk++; if (bus.busy !== 1'b0 || ack_cnt !== 1) begin n_fail++; $display("FAIL wr%0d_done busy=%b acks=%0d want busy=0 acks=1", v, bus.busy, ack_cnt); end
      n_chk++; if (mem[v_pid[v]][v_adr[v]] !== v_wd[v]) begin n_fail++; $display("FAIL wr%0d_ram got=%h want=%h", v, mem[v_pid[v]][v_adr[v]], v_wd[v]); end
    end
  endtask

  task automatic test_bad_pid;
    int acks, busies, wes;
    issue_write(4'd6, 12'h123, 5'h05, 4'h2);
    @(negedge clk);  // N+1
    n_chk++; if (bus.wr_err !== 1'b1) begin n_fail++; $display("FAIL badpid_err got=%b want=1", bus.wr_err); end
    acks = 0; busies = 0; wes = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 2) begin
        n_chk++; if (bus.wr_err !== 1'b0) begin n_fail++; $display("FAIL badpid_err_pulse got=%b want=0", bus.wr_err); end
      end
      if (bus.wr_ack === 1'b1) acks++;
      if (bus.busy === 1'b1) busies++;
      if (bus.lut_we !== 5'h00) wes++;
    end
    n_chk++; if (acks !== 0) begin n_fail++; $display("FAIL badpid_ack got=%0d want=0", acks); end
    n_chk++; if (busies !== 0) begin n_fail++; $display("FAIL badpid_busy got=%0d want=0", busies); end
    n_chk++; if (wes !== 0) begin n_fail++; $display("FAIL badpid_we got=%0d want=0", wes); end
  endtask

  task automatic test_clear_priority;
    int bad, acks;
    @(negedge clk);
    bus.clr_req = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_pid  = 4'd1;
    bus.wr_adr  = 12'h003;
    bus.wr_bend = 5'h11;
    bus.wr_offs = 4'h9;
    @(posedge clk);
    #1 bus.clr_req = 1'b0; bus.wr_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      if (bus.lut_we !== 5'h1F || bus.lut_wdata !== 9'h0E0 || bus.lut_adr !== 12'(i) || bus.wr_ack !== 1'b0)
        bad++;
      // A request while busy must be ignored, not queued
      if (i == 100) begin
        bus.wr_req = 1'b1; bus.clr_req = 1'b1; bus.wr_pid = 4'd2; bus.wr_adr = 12'h007;
      end
      if (i == 101) begin
        bus.wr_req = 1'b0; bus.clr_req = 1'b0;
      end
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL clr_sweep bad_cycles=%0d want=0", bad); end
    @(negedge clk);
    n_chk++; if (bus.wr_ack !== 1'b1 || bus.lut_we !== 5'h00) begin n_fail++; $display("FAIL clr_ack ack=%b we=%h want ack=1 we=00", bus.wr_ack, bus.lut_we); end
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy_fall got=%b want=0", bus.busy); end
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.wr_ack === 1'b1 || bus.lut_we !== 5'h00) acks++;
      @(negedge clk);
    end
    n_chk++; if (acks !== 0) begin n_fail++; $display("FAIL clr_no_queue got=%0d want=0", acks); end
    n_chk++; if (mem[1][12'h003] !== 9'h0E0) begin n_fail++; $display("FAIL clr_dropped_wr got=%h want=0e0", mem[1][12'h003]); end
    n_chk++; if (mem[2][12'h007] !== 9'h0E0) begin n_fail++; $display("FAIL clr_busy_wr got=%h want=0e0", mem[2][12'h007]); end
    n_chk++; if (mem[3][12'h5A5] !== 9'h0E0) begin n_fail++; $display("FAIL clr_overwrite got=%h want=0e0", mem[3][12'h5A5]); end
  endtask

  task automatic test_reset_during_clear;
    int cyc, bad;
    logic hit;
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1 bus.clr_req = 1'b0;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 2100) begin
      @(negedge clk);
      cyc++;
      if (bus.lut_adr === 12'd2000) hit = 1'b1;
    end
    n_chk++; if (!hit) begin n_fail++; $display("FAIL rstclr_reach_2000 got=timeout want=adr 2000"); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.lut_we !== 5'h00 || bus.lut_adr !== 12'h000 || bus.lut_wdata !== 9'h000) begin n_fail++; $display("FAIL rstclr_outputs we=%h adr=%h wd=%h want 0", bus.lut_we, bus.lut_adr, bus.lut_wdata); end
    n_chk++; if (bus.busy !== 1'b0 || bus.wr_ack !== 1'b0) begin n_fail++; $display("FAIL rstclr_ctrl busy=%b ack=%b want 0", bus.busy, bus.wr_ack); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.lut_we !== 5'h00 || bus.wr_ack !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rstclr_aborted got=%0d want=0", bad); end
    @(negedge clk);
    bus.clr_req = 1'b1;
    @(posedge clk);
    #1 bus.clr_req = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.lut_adr !== 12'h000 || bus.lut_we !== 5'h1F) begin n_fail++; $display("FAIL rstclr_restart adr=%h we=%h want 000/1f", bus.lut_adr, bus.lut_we); end
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 4200) begin
      @(negedge clk);
      cyc++;
      if (bus.wr_ack === 1'b1) hit = 1'b1;
    end
    n_chk++; if (cyc !== 4096) begin n_fail++; $display("FAIL rstclr_ack_cycle got=%0d want=4096", cyc); end
    @(negedge clk);
  endtask

  task automatic test_readback;
`ifdef CCLUT_WR_READBACK_EN
    corrupt = 1'b1;
    issue_write(4'd2, 12'h010, 5'h0A, 4'h3);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);  // N+3
    n_chk++; if (bus.rb_err !== 1'b0) begin n_fail++; $display("FAIL rb_early got=%b want=0", bus.rb_err); end
    @(negedge clk);  // N+4
    n_chk++; if (bus.wr_ack !== 1'b1 || bus.rb_err !== 1'b1) begin n_fail++; $display("FAIL rb_set ack=%b rb_err=%b want 1/1", bus.wr_ack, bus.rb_err); end
    @(negedge clk);
    n_chk++; if (bus.rb_err !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL rb_sticky rb_err=%b busy=%b want 1/0", bus.rb_err, bus.busy); end
    corrupt = 1'b0;
    issue_write(4'd2, 12'h010, 5'h0A, 4'h3);
    @(negedge clk);  // N+1
    n_chk++; if (bus.rb_err !== 1'b0) begin n_fail++; $display("FAIL rb_clear got=%b want=0", bus.rb_err); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);  // N+4
    n_chk++; if (bus.wr_ack !== 1'b1 || bus.rb_err !== 1'b0) begin n_fail++; $display("FAIL rb_good ack=%b rb_err=%b want 1/0", bus.wr_ack, bus.rb_err); end
    @(negedge clk);
`else
    int res, rbs;
    corrupt = 1'b1;
    issue_write(4'd2, 12'h010, 5'h0A, 4'h3);
    res = 0; rbs = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.lut_re !== 5'h00) res++;
      if (bus.rb_err !== 1'b0) rbs++;
    end
    n_chk++; if (res !== 0) begin n_fail++; $display("FAIL norb_re got=%0d want=0", res); end
    n_chk++; if (rbs !== 0) begin n_fail++; $display("FAIL norb_rberr got=%0d want=0", rbs); end
    n_chk++; if (mem[2][12'h010] !== 9'h06A) begin n_fail++; $display("FAIL norb_ram got=%h want=06a", mem[2][12'h010]); end
    corrupt = 1'b0;
`endif
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    corrupt     = 1'b0;
    bus.wr_req  = 1'b0;
    bus.clr_req = 1'b0;
    bus.wr_pid  = 4'd0;
    bus.wr_adr  = 12'h000;
    bus.wr_bend = 5'h00;
    bus.wr_offs = 4'h0;
    bus.lut_rdata = 9'h000;
    test_reset();
    test_write();
    test_bad_pid();
    test_clear_priority();
    test_reset_during_clear();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
